// File: rtl/cmos_8_16bit.sv
// DVP capture front-end: packs the 8-bit sensor byte stream into 16-bit
// RGB565 pixels, suppresses the first frames after reset and reports
// per-line/per-frame geometry plus unpaired-byte errors.
module cmos_8_16bit #(
   parameter int unsigned FRAME_SKIP = 10,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter int unsigned CNT_W      = 12
) (
   input  logic             cmos_pclk,
   input  logic             rst_i,
   input  logic             cmos_vsync,
   input  logic             cmos_href,
   input  logic [7:0]       cmos_d,
   output logic             cmos_vsync_16bit,
   output logic             cmos_href_16bit,
   output logic             cmos_de_16bit,
   output logic [15:0]      cmos_d_16bit,
   output logic             frame_en,
   output logic [CNT_W-1:0] line_pixels,
   output logic [CNT_W-1:0] frame_lines,
   output logic             odd_byte_err
);

   localparam int unsigned SKIP_W = (FRAME_SKIP < 2) ? 1 : $clog2(FRAME_SKIP + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP - 1);
   localparam logic [SKIP_W-1:0] SKIP_END  = SKIP_W'(FRAME_SKIP);

   // input stage (S1) and previous-cycle copies for edge detection
   logic             s1_vsync_q, s1_href_q;
   logic [7:0]       s1_d_q;
   logic             s2_vsync_q, s2_href_q;

   logic             phase_q,       phase_d;
   logic [7:0]       hold_q,        hold_d;
   logic [15:0]      d16_q,         d16_d;
   logic             de_q,          de_d;
   logic             href16_q,      href16_d;
   logic             vsync16_q,     vsync16_d;
   logic [SKIP_W-1:0] skip_q,       skip_d;
   logic             frame_en_q,    frame_en_d;
   logic [CNT_W-1:0] pix_cnt_q,     pix_cnt_d;
   logic [CNT_W-1:0] line_cnt_q,    line_cnt_d;
   logic [CNT_W-1:0] line_pix_q,    line_pix_d;
   logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
   logic             odd_err_q,     odd_err_d;

   logic             vs_rise_c, href_fall_c, pair_c;
   logic [CNT_W-1:0] line_cnt_inc_c;

   // state registers
   always_ff @(posedge cmos_pclk or posedge rst_i) begin
      if (rst_i) begin
         s1_vsync_q    <= 1'b0;
         s1_href_q     <= 1'b0;
         s1_d_q        <= '0;
         s2_vsync_q    <= 1'b0;
         s2_href_q     <= 1'b0;
         phase_q       <= 1'b0;
         hold_q        <= '0;
         d16_q         <= '0;
         de_q          <= 1'b0;
         href16_q      <= 1'b0;
         vsync16_q     <= 1'b0;
         skip_q        <= '0;
         frame_en_q    <= 1'b0;
         pix_cnt_q     <= '0;
         line_cnt_q    <= '0;
         line_pix_q    <= '0;
         frame_lines_q <= '0;
         odd_err_q     <= 1'b0;
      end else begin
         s1_vsync_q    <= cmos_vsync;
         s1_href_q     <= cmos_href;
         s1_d_q        <= cmos_d;
         s2_vsync_q    <= s1_vsync_q;
         s2_href_q     <= s1_href_q;
         phase_q       <= phase_d;
         hold_q        <= hold_d;
         d16_q         <= d16_d;
         de_q          <= de_d;
         href16_q      <= href16_d;
         vsync16_q     <= vsync16_d;
         skip_q        <= skip_d;
         frame_en_q    <= frame_en_d;
         pix_cnt_q     <= pix_cnt_d;
         line_cnt_q    <= line_cnt_d;
         line_pix_q    <= line_pix_d;
         frame_lines_q <= frame_lines_d;
         odd_err_q     <= odd_err_d;
      end
   end

   // next-state logic: packing, masking, counters and error tracking
   always_comb begin
      phase_d        = 1'b0;
      hold_d         = hold_q;
      d16_d          = d16_q;
      de_d           = 1'b0;
      href16_d       = s1_href_q & frame_en_q;
      vsync16_d      = s1_vsync_q & frame_en_q;
      skip_d         = skip_q;
      frame_en_d     = frame_en_q;
      pix_cnt_d      = pix_cnt_q;
      line_cnt_d     = line_cnt_q;
      line_pix_d     = line_pix_q;
      frame_lines_d  = frame_lines_q;
      odd_err_d      = odd_err_q;

      vs_rise_c      = s1_vsync_q & ~s2_vsync_q;
      href_fall_c    = ~s1_href_q & s2_href_q;
      pair_c         = s1_href_q & phase_q;
      line_cnt_inc_c = line_cnt_q;

      if (s1_href_q) begin
         phase_d = ~phase_q;
      end

      if (s1_href_q && !phase_q) begin
         hold_d = s1_d_q;
      end

      if (pair_c) begin
         d16_d = MSB_FIRST ? {hold_q, s1_d_q} : {s1_d_q, hold_q};
         de_d  = frame_en_q;
         if (pix_cnt_q != CNT_MAX) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
         end
      end

      // line end: latch pixel count, count the line, flag an unpaired byte
      if (href_fall_c) begin
         line_pix_d = pix_cnt_q;
         pix_cnt_d  = '0;
         if (phase_q) begin
            odd_err_d = 1'b1;
         end
         if (line_cnt_q != CNT_MAX) begin
            line_cnt_inc_c = line_cnt_q + CNT_W'(1);
         end
      end
      line_cnt_d = line_cnt_inc_c;

      // frame start: latch line count (including a line ending this cycle)
      if (vs_rise_c) begin
         frame_lines_d = line_cnt_inc_c;
         line_cnt_d    = '0;
         if (skip_q < SKIP_END) begin
            skip_d = skip_q + SKIP_W'(1);
         end
         if ((FRAME_SKIP == 0) || (skip_q == SKIP_LAST)) begin
            frame_en_d = 1'b1;
         end
      end
   end

   assign cmos_vsync_16bit = vsync16_q;
   assign cmos_href_16bit  = href16_q;
   assign cmos_de_16bit    = de_q;
   assign cmos_d_16bit     = d16_q;
   assign frame_en         = frame_en_q;
   assign line_pixels      = line_pix_q;
   assign frame_lines      = frame_lines_q;
   assign odd_byte_err     = odd_err_q;

endmodule

// File: tb/tb_cmos_8_16bit.sv
// Bench for cmos_8_16bit: two instances on the same stimulus, one with
// FRAME_SKIP=2/MSB_FIRST=1 and one with FRAME_SKIP=0/MSB_FIRST=0.
module tb_cmos_8_16bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        vs, href;
   logic [7:0]  d;

   logic        vs16_a, href16_a, de_a, fen_a, err_a;
   logic [15:0] d16_a;
   logic [11:0] lp_a, fl_a;
   logic        vs16_b, href16_b, de_b, fen_b, err_b;
   logic [15:0] d16_b;
   logic [11:0] lp_b, fl_b;

   int errs   = 0;
   int checks = 0;

   // reference model state
   logic [15:0] q_a[$], q_b[$], exp_a[$], exp_b[$];
   logic [7:0]  lb[32];
   int          vs_cnt  = 0;
   int          lines_m = 0;
   int          fl_m    = 0;
   int          lp_m    = 0;
   bit          err_m   = 0;

   always #5 clk = ~clk;

   cmos_8_16bit #(.FRAME_SKIP(2), .MSB_FIRST(1'b1), .CNT_W(12)) dut_a (
      .cmos_pclk(clk), .rst_i(rst), .cmos_vsync(vs), .cmos_href(href), .cmos_d(d),
      .cmos_vsync_16bit(vs16_a), .cmos_href_16bit(href16_a), .cmos_de_16bit(de_a),
      .cmos_d_16bit(d16_a), .frame_en(fen_a), .line_pixels(lp_a),
      .frame_lines(fl_a), .odd_byte_err(err_a));

   cmos_8_16bit #(.FRAME_SKIP(0), .MSB_FIRST(1'b0), .CNT_W(12)) dut_b (
      .cmos_pclk(clk), .rst_i(rst), .cmos_vsync(vs), .cmos_href(href), .cmos_d(d),
      .cmos_vsync_16bit(vs16_b), .cmos_href_16bit(href16_b), .cmos_de_16bit(de_b),
      .cmos_d_16bit(d16_b), .frame_en(fen_b), .line_pixels(lp_b),
      .frame_lines(fl_b), .odd_byte_err(err_b));

   // collect every strobed pixel
   always @(posedge clk) begin
      #1;
      if (de_a === 1'b1) q_a.push_back(d16_a);
      if (de_b === 1'b1) q_b.push_back(d16_b);
   end

   // drive lb[0:n-1] as one line; gap = low cycles after it (0 keeps href high)
   task automatic send_line(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); href = 1'b1; d = lb[i];
      end
      if (gap > 0) begin
         @(negedge clk); href = 1'b0; d = 8'h00;
         repeat (gap - 1) @(negedge clk);
      end
      for (int p = 0; p < n / 2; p++) begin
         if (vs_cnt >= 2) exp_a.push_back({lb[2*p], lb[2*p+1]});
         if (vs_cnt >= 1) exp_b.push_back({lb[2*p+1], lb[2*p]});
      end
      if (n % 2 != 0) err_m = 1'b1;
      lp_m = n / 2;
      lines_m++;
   endtask

   // vsync pulse; returns dut_a's packed vsync as seen during the pulse
   task automatic send_vsync(output logic seen);
      @(negedge clk); href = 1'b0; d = 8'h00; vs = 1'b1;
      @(negedge clk);
      @(negedge clk); seen = vs16_a; vs = 1'b0;
      repeat (3) @(negedge clk);
      fl_m = lines_m;
      lines_m = 0;
      vs_cnt++;
   endtask

   task automatic test_reset;
      rst = 1'b1; vs = 1'b0; href = 1'b0; d = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({vs16_a, href16_a, de_a, d16_a, fen_a, lp_a, fl_a, err_a} !== '0) begin
         errs++; $display("FAIL reset_a outputs not all zero");
      end
      checks++;
      if ({vs16_b, href16_b, de_b, d16_b, fen_b, lp_b, fl_b, err_b} !== '0) begin
         errs++; $display("FAIL reset_b outputs not all zero");
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_skip_frames;
      logic seen;
      bit   exp_seen;
      for (int f = 1; f <= 3; f++) begin
         for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 8; i++) lb[i] = 8'(i);
            send_line(8, 3);
         end
         checks++;
         if (q_a.size() != exp_a.size() || q_b.size() != exp_b.size()) begin
            errs++; $display("FAIL skip_count frame %0d got a=%0d b=%0d want a=%0d b=%0d",
                             f, q_a.size(), q_b.size(), exp_a.size(), exp_b.size());
         end
         for (int i = 0; i < q_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_a[i]) begin errs++; $display("FAIL skip_pix_a %0d got %h want %h", i, q_a[i], exp_a[i]); end
         end
         for (int i = 0; i < q_b.size() && i < exp_b.size(); i++) begin
            checks++;
            if (q_b[i] !== exp_b[i]) begin errs++; $display("FAIL skip_pix_b %0d got %h want %h", i, q_b[i], exp_b[i]); end
         end
         if (f == 3) begin
            checks++;
            if (q_a.size() < 4 || q_a[3] !== 16'h0607) begin
               errs++; $display("FAIL skip_pix3 want 0607");
            end
         end
         q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
         exp_seen = (vs_cnt >= 2);
         send_vsync(seen);
         checks++;
         if (seen !== exp_seen) begin errs++; $display("FAIL vsync16_mask frame %0d got %b want %b", f, seen, exp_seen); end
         checks++;
         if (fl_a !== 12'(fl_m) || fl_b !== 12'(fl_m) || lp_a !== 12'(lp_m)) begin
            errs++; $display("FAIL geometry frame %0d fl=%0d/%0d lp=%0d want fl=%0d lp=%0d",
                             f, fl_a, fl_b, lp_a, fl_m, lp_m);
         end
         checks++;
         if (fen_a !== (vs_cnt >= 2) || fen_b !== (vs_cnt >= 1)) begin
            errs++; $display("FAIL frame_en frame %0d got a=%b b=%b", f, fen_a, fen_b);
         end
      end
   endtask

   task automatic test_latency;
      @(negedge clk); href = 1'b1; d = 8'hAB;
      @(negedge clk); d = 8'hCD;
      checks++;
      if (href16_a !== 1'b0) begin errs++; $display("FAIL lat_href_early got %b want 0", href16_a); end
      @(negedge clk); href = 1'b0; d = 8'h00;
      checks++;
      if (de_a !== 1'b0 || href16_a !== 1'b1) begin
         errs++; $display("FAIL lat_edge1 de=%b href16=%b want de=0 href16=1", de_a, href16_a);
      end
      @(negedge clk);
      checks++;
      if (de_a !== 1'b1 || d16_a !== 16'hABCD || d16_b !== 16'hCDAB) begin
         errs++; $display("FAIL lat_edge2 de=%b d16=%h/%h want 1 ABCD/CDAB", de_a, d16_a, d16_b);
      end
      @(negedge clk);
      checks++;
      if (de_a !== 1'b0 || d16_a !== 16'hABCD) begin
         errs++; $display("FAIL lat_hold de=%b d16=%h want 0 ABCD", de_a, d16_a);
      end
      repeat (2) @(negedge clk);
      lines_m++; lp_m = 1;
      q_a.delete(); q_b.delete();
      lb[0] = 8'h12; lb[1] = 8'h34;
      send_line(2, 3);
      checks++;
      if (q_b.size() != 1 || q_b[0] !== 16'h3412 || q_a.size() != 1 || q_a[0] !== 16'h1234) begin
         errs++; $display("FAIL lsb_first got %0d pixels want 3412 in b and 1234 in a", q_b.size());
      end
      q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
   endtask

   task automatic test_odd_line;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 8; i++) lb[i] = 8'($urandom);
         send_line(pass == 0 ? 7 : 8, 3);
         checks++;
         if (q_a.size() != exp_a.size() || q_b.size() != exp_b.size()) begin
            errs++; $display("FAIL odd_count pass %0d got %0d want %0d", pass, q_a.size(), exp_a.size());
         end
         for (int i = 0; i < q_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i]) begin
               errs++; $display("FAIL odd_pix %0d got %h/%h want %h/%h", i, q_a[i], q_b[i], exp_a[i], exp_b[i]);
            end
         end
         checks++;
         if (lp_a !== 12'(lp_m) || err_a !== 1'b1 || err_b !== 1'b1) begin
            errs++; $display("FAIL odd_flags pass %0d lp=%0d err=%b/%b want lp=%0d err=1", pass, lp_a, err_a, err_b, lp_m);
         end
         q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      send_line(4, 1);
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      send_line(4, 3);
      checks++;
      if (q_a.size() != 4 || q_b.size() != 4) begin
         errs++; $display("FAIL b2b_count got %0d/%0d want 4", q_a.size(), q_b.size());
      end
      for (int i = 0; i < q_a.size() && i < exp_a.size(); i++) begin
         checks++;
         if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i]) begin
            errs++; $display("FAIL b2b_pix %0d got %h/%h want %h/%h", i, q_a[i], q_b[i], exp_a[i], exp_b[i]);
         end
      end
      checks++;
      if (lp_a !== 12'd2) begin errs++; $display("FAIL b2b_lp got %0d want 2", lp_a); end
      q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
   endtask

   task automatic test_random;
      logic seen;
      for (int f = 0; f < 4; f++) begin
         int nl;
         nl = $urandom_range(1, 5);
         for (int l = 0; l < nl; l++) begin
            int n;
            n = $urandom_range(2, 20);
            for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
            // odd frames end a line in the same cycle as the vsync rise
            send_line(n, (l == nl - 1 && f % 2 == 1) ? 0 : $urandom_range(1, 4));
         end
         send_vsync(seen);
         checks++;
         if (q_a.size() != exp_a.size() || q_b.size() != exp_b.size()) begin
            errs++; $display("FAIL rnd_count frame %0d got %0d/%0d want %0d/%0d",
                             f, q_a.size(), q_b.size(), exp_a.size(), exp_b.size());
         end
         for (int i = 0; i < q_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i]) begin
               errs++; $display("FAIL rnd_pix %0d got %h/%h want %h/%h", i, q_a[i], q_b[i], exp_a[i], exp_b[i]);
            end
         end
         checks++;
         if (fl_a !== 12'(fl_m) || fl_b !== 12'(fl_m) || lp_a !== 12'(lp_m) || err_a !== err_m) begin
            errs++; $display("FAIL rnd_geom frame %0d fl=%0d lp=%0d err=%b want fl=%0d lp=%0d err=%b",
                             f, fl_a, lp_a, err_a, fl_m, lp_m, err_m);
         end
         q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
      end
   endtask

   task automatic test_reset_mid;
      logic seen;
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); href = 1'b1; d = lb[i];
      end
      @(negedge clk);
      #2 rst = 1'b1; href = 1'b0; d = 8'h00;
      #1;
      checks++;
      if ({vs16_a, href16_a, de_a, d16_a, fen_a, lp_a, fl_a, err_a} !== '0 ||
          {vs16_b, href16_b, de_b, d16_b, fen_b, lp_b, fl_b, err_b} !== '0) begin
         errs++; $display("FAIL rst_mid outputs not cleared asynchronously");
      end
      checks++;
      if (q_a.size() != 1 || q_a[0] !== {lb[0], lb[1]} || q_b.size() != 1 || q_b[0] !== {lb[1], lb[0]}) begin
         errs++; $display("FAIL rst_mid_pair got %0d/%0d pixels want 1/1", q_a.size(), q_b.size());
      end
      q_a.delete(); q_b.delete();
      vs_cnt = 0; lines_m = 0; lp_m = 0; err_m = 1'b0;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      send_vsync(seen);
      checks++;
      if (fen_a !== 1'b0 || fen_b !== 1'b1) begin
         errs++; $display("FAIL rst_skip got a=%b b=%b want a=0 b=1", fen_a, fen_b);
      end
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
         send_line(4, 3);
         checks++;
         if (q_a.size() != exp_a.size() || q_b.size() != exp_b.size()) begin
            errs++; $display("FAIL rst_line_count pass %0d got %0d/%0d want %0d/%0d",
                             pass, q_a.size(), q_b.size(), exp_a.size(), exp_b.size());
         end
         for (int i = 0; i < q_b.size() && i < exp_b.size(); i++) begin
            checks++;
            if (q_b[i] !== exp_b[i]) begin errs++; $display("FAIL rst_pix_b %0d got %h want %h", i, q_b[i], exp_b[i]); end
         end
         for (int i = 0; i < q_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (q_a[i] !== exp_a[i]) begin errs++; $display("FAIL rst_pix_a %0d got %h want %h", i, q_a[i], exp_a[i]); end
         end
         q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
         if (pass == 0) begin
            send_vsync(seen);
            checks++;
            if (fen_a !== 1'b1 || fl_a !== 12'(fl_m) || err_a !== 1'b0) begin
               errs++; $display("FAIL rst_reenable fen=%b fl=%0d err=%b want 1 %0d 0", fen_a, fl_a, err_a, fl_m);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_skip_frames;
      test_latency;
      test_odd_line;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
